// File: rtl/my_nios2_system_cpu_oci_dct_ctrl.sv
// my_nios2_system_cpu_oci_dct_ctrl
// Packs 2-bit DCT trace codes into a 30-bit buffer, closes frames when the
// buffer fills or a flush is requested, and hands closed frames out through
// a one-entry valid/ready output register.
//
// Handshakes (strict valid/ready): a code transfers on a rising edge where
// code_valid & code_ready are both high; a frame transfers on a rising edge
// where frame_valid & frame_ready are both high. Neither ready depends on
// its own valid, and frame_data/frame_count hold stable while frame_valid
// waits for frame_ready.
//
// Build option: define DCT_OVERFLOW_DROP_EN to keep code_ready high while
// full and drop the offered code (flagged by the sticky overflow output)
// instead of back-pressuring the trace front end.
module my_nios2_system_cpu_oci_dct_ctrl #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 15,
  parameter int CNT_W  = 4,
  localparam int BUF_W = CODE_W * DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trace_en,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  input  logic              flush_req,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [BUF_W-1:0]  frame_data,
  output logic [CNT_W-1:0]  frame_count,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t             state, state_nxt;
  logic               flush_pend, pend_nxt;
  logic               slot_free, full, accept, flush_eff, do_close;
  logic [BUF_W-1:0]   shifted, src_buf, close_buf, buf_nxt;
  logic [CNT_W-1:0]   src_cnt, close_cnt, cnt_nxt;

  assign fsm_state = state;

  // Slot is free when empty or being emptied this cycle; full means no room for a code
  always_comb begin
    slot_free = !frame_valid || frame_ready;
    full      = (dct_count == DEPTH_C);
`ifdef DCT_OVERFLOW_DROP_EN
    code_ready = trace_en && (state == S_FILL);
`else
    code_ready = trace_en && (state == S_FILL) && (!full || slot_free);
`endif
    accept = code_valid && code_ready && (!full || slot_free);
  end

  // Pack/close datapath: decide what the frame gets and what stays in the buffer
  always_comb begin
    flush_eff = flush_req || flush_pend || (state == S_DRAIN);
    shifted   = {dct_buffer[BUF_W-CODE_W-1:0], code};
    src_buf   = dct_buffer;
    src_cnt   = dct_count;
    close_buf = dct_buffer;
    close_cnt = dct_count;
    buf_nxt   = dct_buffer;
    cnt_nxt   = dct_count;
    do_close  = 1'b0;
    if (full) begin
      // A full buffer closes as-is; a code accepted alongside starts the next frame
      do_close = slot_free;
      if (do_close) begin
        buf_nxt = accept ? BUF_W'(code) : '0;
        cnt_nxt = accept ? CNT_W'(1) : '0;
      end
    end else begin
      if (accept) begin
        src_buf = shifted;
        src_cnt = dct_count + CNT_W'(1);
      end
      close_buf = src_buf;
      close_cnt = src_cnt;
      do_close  = slot_free && ((src_cnt == DEPTH_C) || (flush_eff && (src_cnt != '0)));
      buf_nxt   = do_close ? '0 : src_buf;
      cnt_nxt   = do_close ? '0 : src_cnt;
    end
    // A flush waits only while there is something left to close
    pend_nxt = !do_close && flush_eff && (src_cnt != '0);
  end

  // Next-state logic: IDLE until enabled, FILL while enabled, DRAIN until empty
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trace_en) state_nxt = S_FILL;
      S_FILL:  if (!trace_en) state_nxt = S_DRAIN;
      S_DRAIN: if (dct_count == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Pack buffer, code count and pending flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
    end else begin
      dct_buffer <= buf_nxt;
      dct_count  <= cnt_nxt;
      flush_pend <= pend_nxt;
    end
  end

  // One-entry output register: load on close, empty on handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_count <= '0;
    end else if (do_close) begin
      frame_valid <= 1'b1;
      frame_data  <= close_buf;
      frame_count <= close_cnt;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

`ifdef DCT_OVERFLOW_DROP_EN
  logic drop;
  assign drop = code_valid && code_ready && full && !slot_free;

  // Sticky drop flag; a new drop wins over a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = overflow_clr;
  assign overflow   = 1'b0;
`endif

endmodule
